// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Optional build macro MULDIV_EARLY_OUT_EN: multiply exits as soon as the multiplier runs out.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for start, MTHI/MTLO allowed
    // PREP  | take operand magnitudes, record result signs
    // ITER  | one shift-add or restoring-divide step per cycle
    // FIX   | apply signs, write HI/LO on the exit edge
    // DONE  | one-cycle done pulse, otherwise identical to IDLE
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] ITER = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int CW = $clog2(STEPS);

    logic [2:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_sign;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_idle;
    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_q_sh;
    logic [WIDTH:0]     w_t;
    logic               w_last_step;
    logic               w_prep_skip;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_idle   = (r_state == IDLE) || (r_state == DONE);
    assign w_accept = w_idle && start && !flush;

    assign w_abs_a = (r_sign && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
    assign w_abs_b = (r_sign && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;

    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;

    // Restoring divide: 33-bit trial subtract, sign bit of the difference decides.
    assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
    assign w_q_sh   = {r_q[WIDTH-2:0], 1'b0};
    assign w_t      = w_rem_sh - {1'b0, r_divisor};

`ifdef MULDIV_EARLY_OUT_EN
    assign w_last_step = (r_count == CW'(STEPS - 1)) ||
                         (!r_is_div && (w_mplier_next == '0));
    assign w_prep_skip = !r_is_div && (w_abs_b == '0);
`else
    assign w_last_step = (r_count == CW'(STEPS - 1));
    assign w_prep_skip = 1'b0;
`endif

    // Divide by zero leaves q all ones; keep it that way regardless of operand signs.
    assign w_prod    = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_q_fix   = (r_neg_q && !r_div0) ? (~r_q + 1'b1) : r_q;
    assign w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    assign w_res_hi  = r_is_div ? w_rem_fix : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo  = r_is_div ? w_q_fix   : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_is_div  <= 1'b0;
            r_sign    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_divisor <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_is_div <= is_div;
                        r_sign   <= sign;
                        r_state  <= PREP;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                PREP: begin
                    r_neg_q   <= r_sign && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r   <= r_sign && r_a[WIDTH-1];
                    r_div0    <= (r_b == '0);
                    r_count   <= '0;
                    r_acc     <= '0;
                    r_mcand   <= {{WIDTH{1'b0}}, w_abs_a};
                    r_mplier  <= w_abs_b;
                    r_rem     <= '0;
                    r_q       <= w_abs_a;
                    r_divisor <= w_abs_b;
                    r_state   <= w_prep_skip ? FIX : ITER;
                end
                ITER: begin
                    if (r_is_div) begin
                        if (!w_t[WIDTH]) begin
                            r_rem <= w_t[WIDTH-1:0];
                            r_q   <= w_q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            r_rem <= w_rem_sh[WIDTH-1:0];
                            r_q   <= w_q_sh;
                        end
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= w_mplier_next;
                    end
                    r_count <= r_count + 1'b1;
                    if (w_last_step) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // HI/LO: result on the FIX edge, MTHI/MTLO only when idle and no op is being launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!flush) begin
            if (r_state == FIX) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_idle && !w_accept) begin
                if (hi_we) begin
                    r_hi <= wdata;
                end
                if (lo_we) begin
                    r_lo <= wdata;
                end
            end
        end
    end

    assign busy = (r_state == PREP) || (r_state == ITER) || (r_state == FIX);
    assign done = (r_state == DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; latency expectations follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_div;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    muldiv_seq #(.WIDTH(32), .STEPS(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .is_div (is_div),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives start for one edge (edge 1) and returns at the following negedge.
    task automatic issue(input logic dv, input logic sg, input logic [31:0] a_in, input logic [31:0] b_in);
        @(negedge clk);
        start  = 1'b1;
        is_div = dv;
        sign   = sg;
        a      = a_in;
        b      = b_in;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic dv, input logic sg,
                          input logic [31:0] a_in, input logic [31:0] b_in,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int lat_base, input int lat_eo);
        int edges;
        issue(dv, sg, a_in, b_in);
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(edges);
        check_val({tag, "_lat"}, 64'(edges), 64'(EO ? lat_eo : lat_base));
        check_val({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_val({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check_val({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        hi_we = whi;
        lo_we = wlo;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    initial begin
        int edges;
        int n_done;
        logic [31:0] saved_lo;

        reset  = 1'b1;
        start  = 1'b0;
        is_div = 1'b0;
        sign   = 1'b0;
        a      = '0;
        b      = '0;
        flush  = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_op("multu_max",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 35, 35);
        run_op("mult_m3x7",   1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 35, 6);
        run_op("mult_7xm3",   1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 35, 5);
        run_op("mult_m1xm1",  1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 35, 4);
        run_op("divu_100_7",  1'b1, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 35, 35);
        run_op("div_m7_2",    1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 35);
        run_op("divu_big_2",  1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 35, 35);
        run_op("div_by0",     1'b1, 1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 35, 35);
        run_op("div_neg_by0", 1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 35, 35);
        run_op("divu_by0",    1'b1, 1'b0, 32'h87654321, 32'h00000000, 32'h87654321, 32'hFFFFFFFF, 35, 35);
        run_op("div_ovf",     1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 35, 35);
        run_op("multu_5x3",   1'b0, 1'b0, 32'd5,        32'd3,        32'h00000000, 32'h0000000F, 35, 5);
        run_op("multu_x0",    1'b0, 1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 35, 3);

        // MTLO in idle
        write_hilo(1'b0, 1'b1, 32'h13579BDF);
        check_val("mtlo_idle", 64'(lo), 64'h13579BDF);

        // Flush at ITER step 10 (edge 13)
        write_hilo(1'b1, 1'b0, 32'hAAAA5555);
        check_val("mthi_idle", 64'(hi), 64'hAAAA5555);
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_val("flush_busy", 64'(busy), 64'd0);
        check_val("flush_done", 64'(done), 64'd0);
        check_val("flush_hi", 64'(hi), 64'hAAAA5555);
        check_val("flush_lo", 64'(lo), 64'h13579BDF);
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n_done++;
        end
        check_val("flush_no_done", 64'(n_done), 64'd0);

        // Same run, reset instead of flush
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check_val("rstmid_busy", 64'(busy), 64'd0);
        check_val("rstmid_hi", 64'(hi), 64'd0);
        check_val("rstmid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // MTHI while busy is dropped
        write_hilo(1'b1, 1'b0, 32'hCAFEF00D);
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h00000001;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        check_val("mthi_busy_hi", 64'(hi), 64'hCAFEF00D);
        wait_done(edges);
        check_val("mthi_busy_res_hi", 64'(hi), 64'h00000002);
        check_val("mthi_busy_res_lo", 64'(lo), 64'h0000000E);

        // start and MTLO in the same cycle: write dropped, op runs
        @(negedge clk);
        saved_lo = 32'h0000000E;
        start  = 1'b1;
        is_div = 1'b0;
        sign   = 1'b0;
        a      = 32'd6;
        b      = 32'd7;
        lo_we  = 1'b1;
        wdata  = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        lo_we  = 1'b0;
        check_val("st_mtlo_busy", 64'(busy), 64'd1);
        check_val("st_mtlo_lo_hold", 64'(lo), 64'(saved_lo));
        wait_done(edges);
        check_val("st_mtlo_lat", 64'(edges), 64'(EO ? 6 : 35));
        check_val("st_mtlo_lo", 64'(lo), 64'h0000002A);
        check_val("st_mtlo_hi", 64'(hi), 64'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
